// File: rtl/rb_pkg.sv
// Shared definitions for the register bank: write-operation encodings
// used by the RTL and by the bench.
package rb_pkg;

    typedef enum logic [2:0] {
        MODE_LOAD = 3'd0,
        MODE_INC  = 3'd1,
        MODE_DEC  = 3'd2,
        MODE_ADD  = 3'd3,
        MODE_SHL  = 3'd4,
        MODE_SHR  = 3'd5,
        MODE_CLR  = 3'd6,
        MODE_HOLD = 3'd7
    } rb_mode_e;

endpackage

// File: rtl/reg_bank_if.sv
// Bus bundle for reg_bank: one write port with operation select, two
// registered read ports and the port-A sticky-overflow flag.
interface reg_bank_if
    import rb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);

    logic             load;
    rb_mode_e         mode;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic             ovf_clr;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             ovf_a;

    modport master (
        output load, mode, waddr, data_in, raddr_a, raddr_b, ovf_clr,
        input  data_a, data_b, ovf_a
    );

    modport slave (
        input  load, mode, waddr, data_in, raddr_a, raddr_b, ovf_clr,
        output data_a, data_b, ovf_a
    );

endinterface

// File: rtl/rb_alu.sv
// Combinational next-value and overflow computation for one register.
// All arithmetic wraps modulo 2^WIDTH.
module rb_alu
    import rb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] cur,
    input  rb_mode_e         mode,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum    = {1'b0, cur} + {1'b0, operand};
        result = cur;
        ovf    = 1'b0;
        case (mode)
            MODE_LOAD: result = operand;
            MODE_INC: begin
                result = cur + WIDTH'(1);
                ovf    = &cur;
            end
            MODE_DEC: begin
                result = cur - WIDTH'(1);
                ovf    = ~|cur;
            end
            MODE_ADD: begin
                result = sum[WIDTH-1:0];
                ovf    = sum[WIDTH];
            end
            MODE_SHL: begin
                result = {cur[WIDTH-2:0], 1'b0};
                ovf    = cur[WIDTH-1];
            end
            MODE_SHR:  result = {1'b0, cur[WIDTH-1:1]};
            MODE_CLR:  result = '0;
            MODE_HOLD: result = cur;
            default:   result = cur;
        endcase
    end

endmodule

// File: rtl/reg_bank.sv
// Register bank with one operate-on-write port, two write-first registered
// read ports and a per-register sticky overflow flag.
module reg_bank
    import rb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    reg_bank_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] ovf_q;
    logic [DEPTH-1:0] ovf_d;
    logic [WIDTH-1:0] data_a_q, data_a_d;
    logic [WIDTH-1:0] data_b_q, data_b_d;
    logic             ovf_a_q, ovf_a_d;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic [AW-1:0]    waddr;

    assign waddr = bus.waddr;

    rb_alu #(.WIDTH(WIDTH)) u_alu (
        .cur     (regs_q[waddr]),
        .mode    (bus.mode),
        .operand (bus.data_in),
        .result  (alu_result),
        .ovf     (alu_ovf)
    );

    // Reads sample the post-write state so a same-cycle write is visible,
    // and ovf_clr is applied last so it beats a simultaneous overflow.
    always_comb begin
        regs_d = regs_q;
        ovf_d  = ovf_q;
        if (bus.load) begin
            regs_d[waddr] = alu_result;
            if (alu_ovf) begin
                ovf_d[waddr] = 1'b1;
            end
        end
        if (bus.ovf_clr) begin
            ovf_d[waddr] = 1'b0;
        end
        data_a_d = regs_d[bus.raddr_a];
        data_b_d = regs_d[bus.raddr_b];
        ovf_a_d  = ovf_d[bus.raddr_a];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            ovf_q    <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            ovf_a_q  <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            ovf_q    <= ovf_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            ovf_a_q  <= ovf_a_d;
        end
    end

    assign bus.data_a = data_a_q;
    assign bus.data_b = data_b_q;
    assign bus.ovf_a  = ovf_a_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: a table of write/read vectors with
// hand-computed results, plus an asynchronous-reset sequence.
module tb_reg_bank;
    import rb_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef struct {
        logic             load;
        rb_mode_e         mode;
        logic [AW-1:0]    waddr;
        logic [WIDTH-1:0] data_in;
        logic [AW-1:0]    raddr_a;
        logic [AW-1:0]    raddr_b;
        logic             ovf_clr;
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;
        logic             exp_ovf;
        string            name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t vecs[$];

    reg_bank_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic l, input rb_mode_e m, input logic [AW-1:0] wa,
                           input logic [WIDTH-1:0] d, input logic [AW-1:0] ra,
                           input logic [AW-1:0] rb, input logic clr,
                           input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                           input logic eo, input string n);
        vec_t v;
        v.load = l; v.mode = m; v.waddr = wa; v.data_in = d;
        v.raddr_a = ra; v.raddr_b = rb; v.ovf_clr = clr;
        v.exp_a = ea; v.exp_b = eb; v.exp_ovf = eo; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic l, input rb_mode_e m, input logic [AW-1:0] wa,
                                 input logic [WIDTH-1:0] d, input logic [AW-1:0] ra,
                                 input logic [AW-1:0] rb, input logic clr);
        bus.load    = l;
        bus.mode    = m;
        bus.waddr   = wa;
        bus.data_in = d;
        bus.raddr_a = ra;
        bus.raddr_b = rb;
        bus.ovf_clr = clr;
    endtask

    task automatic checkOutput(input string n, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", n, act, exp);
        end
    endtask

    task automatic check_all(input string n, input logic [WIDTH-1:0] ea,
                             input logic [WIDTH-1:0] eb, input logic eo);
        checkOutput({n, ".data_a"}, bus.data_a, ea);
        checkOutput({n, ".data_b"}, bus.data_b, eb);
        checkOutput({n, ".ovf_a"}, {15'd0, bus.ovf_a}, {15'd0, eo});
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //       load mode       wa  data     ra  rb  clr exp_a    exp_b    ovf  name
        add_vec(1, MODE_LOAD, 3, 16'h00FE, 3, 0, 0, 16'h00FE, 16'h0000, 0, "load_r3");
        add_vec(0, MODE_ADD,  3, 16'h0FE6, 3, 3, 0, 16'h00FE, 16'h00FE, 0, "idle1_r3");
        add_vec(0, MODE_ADD,  3, 16'h0FE6, 3, 3, 0, 16'h00FE, 16'h00FE, 0, "idle2_r3");
        add_vec(1, MODE_ADD,  3, 16'h0FE6, 3, 3, 0, 16'h10E4, 16'h10E4, 0, "add_r3");
        add_vec(1, MODE_LOAD, 0, 16'hFFFF, 0, 3, 0, 16'hFFFF, 16'h10E4, 0, "load_r0");
        add_vec(1, MODE_INC,  0, 16'h0000, 0, 3, 0, 16'h0000, 16'h10E4, 1, "inc_wrap_r0");
        add_vec(1, MODE_LOAD, 0, 16'h1234, 0, 3, 0, 16'h1234, 16'h10E4, 1, "load_sticky_r0");
        add_vec(0, MODE_LOAD, 0, 16'h0000, 0, 3, 1, 16'h1234, 16'h10E4, 0, "ovf_clr_r0");
        add_vec(1, MODE_LOAD, 1, 16'h8001, 1, 0, 0, 16'h8001, 16'h1234, 0, "load_r1");
        add_vec(1, MODE_SHL,  1, 16'h0000, 1, 0, 0, 16'h0002, 16'h1234, 1, "shl_r1");
        add_vec(1, MODE_LOAD, 2, 16'h8001, 2, 1, 0, 16'h8001, 16'h0002, 0, "load_r2");
        add_vec(1, MODE_SHR,  2, 16'h0000, 2, 1, 0, 16'h4000, 16'h0002, 0, "shr_r2");
        add_vec(1, MODE_DEC,  4, 16'h0000, 4, 2, 0, 16'hFFFF, 16'h4000, 1, "dec_zero_r4");
        add_vec(1, MODE_LOAD, 5, 16'hABCD, 5, 5, 0, 16'hABCD, 16'hABCD, 0, "bypass_r5");
        add_vec(1, MODE_LOAD, 6, 16'hF000, 6, 5, 0, 16'hF000, 16'hABCD, 0, "load_r6");
        add_vec(1, MODE_ADD,  6, 16'h2000, 6, 5, 0, 16'h1000, 16'hABCD, 1, "add_carry_r6");
        add_vec(1, MODE_INC,  4, 16'h0000, 4, 0, 1, 16'h0000, 16'h1234, 0, "clr_beats_set_r4");
        add_vec(1, MODE_CLR,  1, 16'h0000, 1, 3, 0, 16'h0000, 16'h10E4, 1, "clr_keeps_ovf_r1");
        add_vec(1, MODE_CLR,  3, 16'h0000, 3, 1, 0, 16'h0000, 16'h0000, 0, "clr_r3");
        add_vec(1, MODE_HOLD, 2, 16'hFFFF, 2, 3, 0, 16'h4000, 16'h0000, 0, "hold_r2");
        add_vec(0, MODE_LOAD, 0, 16'h0000, 6, 1, 0, 16'h1000, 16'h0000, 1, "read_r6_r1");

        applyStimulus(0, MODE_HOLD, 0, 16'h0000, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 16'h0000, 16'h0000, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].load, vecs[i].mode, vecs[i].waddr, vecs[i].data_in,
                          vecs[i].raddr_a, vecs[i].raddr_b, vecs[i].ovf_clr);
            @(posedge clk);
            #1;
            check_all(vecs[i].name, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_ovf);
        end

        // Reset dropped mid-cycle while a write is pending on r5.
        applyStimulus(1, MODE_LOAD, 5, 16'h5555, 5, 5, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 16'h0000, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_held_edge", 16'h0000, 16'h0000, 1'b0);
        rst_n = 1'b1;

        applyStimulus(0, MODE_LOAD, 0, 16'h0000, 5, 6, 0);
        @(posedge clk);
        #1;
        check_all("post_rst_r5_r6", 16'h0000, 16'h0000, 1'b0);
        applyStimulus(0, MODE_LOAD, 0, 16'h0000, 1, 0, 0);
        @(posedge clk);
        #1;
        check_all("post_rst_ovf_r1", 16'h0000, 16'h0000, 1'b0);

        // First edge after release must take the write.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        applyStimulus(1, MODE_LOAD, 7, 16'h7777, 7, 7, 0);
        @(posedge clk);
        #1;
        check_all("first_write_r7", 16'h7777, 16'h7777, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
